// File: rtl/instr_fifo.sv
// instr_fifo: single-clock first-word-fall-through instruction queue for one
// pipeline lane. The arbiter pushes instructions in and the lane's fetch/decode
// stage pops them. Full and almost-full go back to the arbiter. Dropped pushes
// and pops on an empty queue are recorded as sticky error flags.
module instr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(DEPTH);

    // Storage array. It is deliberately not reset: count alone decides what is valid.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_evt;
    logic w_unf_evt;

    // Derive status and effective push/pop. Flush suppresses traffic and errors.
    // A push while full is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        w_push    = wr_en & (~w_full | rd_en) & ~flush;
        w_pop     = rd_en & ~w_empty & ~flush;
        w_ovf_evt = wr_en & w_full & ~rd_en & ~flush;
        w_unf_evt = rd_en & w_empty & ~flush;
    end

    // Write accepted instructions at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= instr_in;
        end
    end

    // Update the pointers and occupancy. Flush empties the queue in one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags. A same-cycle error event wins over clr_err.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Present the head combinationally, forced to zero while the queue is empty.
    always_comb begin
        instr_out   = w_empty ? '0 : r_mem[r_rp];
        valid       = ~w_empty;
        empty       = w_empty;
        full        = w_full;
        almost_full = (r_count >= CW'(AF_LEVEL));
        count       = r_count;
        overflow    = r_overflow;
        underflow   = r_underflow;
    end
endmodule

// File: tb/tb_instr_fifo.sv
// Directed plus short random bench for instr_fifo (DEPTH=8, AF_LEVEL=6).
// Handshake: a push is taken at a rising edge when wr_en=1 and (full=0 or rd_en=1).
// A pop is taken when rd_en=1 and empty=0. Flush overrides both.
module tb_instr_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int CW = 4;

    logic          clk;
    logic          resetn;
    logic          wr_en;
    logic [DW-1:0] instr_in;
    logic          rd_en;
    logic          flush;
    logic          clr_err;
    logic [DW-1:0] instr_out;
    logic          valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    instr_fifo dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .instr_in   (instr_in),
        .rd_en      (rd_en),
        .flush      (flush),
        .clr_err    (clr_err),
        .instr_out  (instr_out),
        .valid      (valid),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference state
    logic [DW-1:0] exp_q[$];
    int            m_count;
    logic          m_ovf;
    logic          m_unf;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk({tag, ".count"},     32'(count),       32'(m_count));
        chk({tag, ".empty"},     32'(empty),       32'(m_count == 0));
        chk({tag, ".valid"},     32'(valid),       32'(m_count != 0));
        chk({tag, ".full"},      32'(full),        32'(m_count == DEPTH));
        chk({tag, ".afull"},     32'(almost_full), 32'(m_count >= 6));
        chk({tag, ".overflow"},  32'(overflow),    32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow),   32'(m_unf));
        chk({tag, ".instr_out"}, instr_out,        head);
    endtask

    // Driver: one clock cycle of stimulus. It is entered and left at posedge+1.
    task automatic step(input string tag, input logic we, input logic [DW-1:0] d,
                        input logic re, input logic fl, input logic ce);
        logic p_push;
        logic p_pop;
        wr_en = we; instr_in = d; rd_en = re; flush = fl; clr_err = ce;
        #1;
        if (fl) begin
            exp_q.delete();
            m_count = 0;
            if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end else begin
            p_push = we && (m_count < DEPTH || re);
            p_pop  = re && (m_count > 0);
            if (p_pop) chk({tag, ".pop_data"}, instr_out, exp_q.pop_front());
            if (p_push) exp_q.push_back(d);
            m_count = m_count + int'(p_push) - int'(p_pop);
            if (we && !re && !p_push) m_ovf = 1'b1;
            else if (ce) m_ovf = 1'b0;
            if (re && !p_pop) m_unf = 1'b1;
            else if (ce) m_unf = 1'b0;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; instr_in = '0;
        check_state(tag);
    endtask

    task automatic push(input string tag, input logic [DW-1:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        resetn = 1'b0; wr_en = 1'b0; instr_in = '0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_state("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Three pushes with no reads, then three pops.
        push("t1_push", 32'h0004_5678);
        push("t1_push", 32'h0005_678A);
        push("t1_push", 32'h0006_78AB);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_head", instr_out, 32'h0004_5678);
        for (int i = 0; i < 3; i++) pop("t1_pop");

        // Fill to full, then drop a 9th push, then drain.
        for (int i = 0; i < 8; i++) push("t2_fill", 32'h10 + 32'(i));
        push("t2_ovf", 32'hFF);
        for (int i = 0; i < 8; i++) pop("t2_drain");
        step("t2_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Wrap-around of both pointers.
        for (int i = 0; i < 6; i++) push("t3_push6", $urandom);
        for (int i = 0; i < 6; i++) pop("t3_pop6");
        for (int i = 0; i < 8; i++) push("t3_push8", 32'hA0 + 32'(i));
        for (int i = 0; i < 8; i++) pop("t3_pop8");

        // Simultaneous push and pop while full, then while empty.
        for (int i = 0; i < 8; i++) push("t4_fill", 32'h30 + 32'(i));
        step("t4_full_rw", 1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pop("t4_drain");
        step("t4_empty_rw", 1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
        step("t4_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        pop("t4_pop");

        // Flush with a simultaneous push.
        for (int i = 0; i < 5; i++) push("t5_push", 32'h50 + 32'(i));
        step("t5_flush", 1'b1, 32'hDD, 1'b0, 1'b1, 1'b0);

        // Random mixed traffic.
        for (int i = 0; i < 60; i++)
            step("t6_rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));

        // Asynchronous reset between edges while holding data.
        step("t7_clr", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push("t7_push", 32'h70 + 32'(i));
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_state("t7_async_rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        push("t7_after", 32'h77);
        pop("t7_after_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fifo.md
# instr_fifo

Single-clock, first-word-fall-through instruction queue that receives instructions from the arbiter and holds them for one pipeline lane; the design instantiates two, written by `FIFO_1_en` and `FIFO_2_en` respectively. It is the consumer end of the arbiter's `instr_out`/`FIFO_x_en` interface. It buffers up to DEPTH 32-bit instructions in order and presents the head to the lane's fetch/decode stage, which pops with `rd_en`. It flags full/almost-full back toward the arbiter and records overflow/underflow as sticky errors.

## Interface
- DATA_WIDTH, 32, instruction width.
- DEPTH, 8, entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL.
- CW, $clog2(DEPTH)+1, count width (derived; not overridden).

- clk  in  1  rising-edge clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  push; connected to the arbiter's `FIFO_1_en` or `FIFO_2_en`.
- instr_in  in  DATA_WIDTH  instruction to push; the arbiter's `instr_out`.
- rd_en  in  1  pop head (lane consumer).
- flush  in  1  synchronous clear of contents (e.g. redirect).
- clr_err  in  1  synchronous clear of sticky error flags.
- instr_out  out  DATA_WIDTH  head entry; 0 while empty.
- valid  out  1  head is valid (equals !empty).
- empty  out  1  no entries.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop hit empty.

## Operation
- Storage: DEPTH×DATA_WIDTH register array (not reset), write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, plus a CW-bit `count` register. Full/empty derive from `count`.
- Effective push: `push = wr_en & (!full | rd_en)`. Effective pop: `pop = rd_en & !empty`.
- Push writes `instr_in` to mem[wp]; wp increments modulo DEPTH (natural wrap at DEPTH-1 → 0).
- Pop increments rp modulo DEPTH.
- count' = count + push − pop.
- FWFT: `instr_out = empty ? 0 : mem[rp]`, combinational from registered state.
- Full plus simultaneous wr_en and rd_en: both occur, and count stays at DEPTH.
- Empty plus simultaneous wr_en and rd_en: only the push occurs. count becomes 1, and underflow is set.
- wr_en while full without rd_en: the data is dropped and `overflow` is set.
- rd_en while empty: no state change except `underflow` is set.
- flush (highest priority after reset): wp, rp and count go to 0 next edge. Any same-cycle wr_en/rd_en is ignored and no error is flagged. Sticky flags are unaffected.
- clr_err clears overflow/underflow. If an error event occurs in the same cycle, the set wins.
- Reset (asserted any time, including mid-burst): wp=rp=count=0, overflow=underflow=0. Outputs go immediately to empty=1, valid=0, full=0, almost_full=0, count=0, instr_out=0. Prior contents are considered lost.

## Timing
- All state updates occur on the rising edge of clk. Reset acts asynchronously on assertion; deassertion is assumed synchronized upstream.
- Write-to-visible latency: an entry pushed into an empty FIFO at edge N appears on instr_out/valid right after edge N (1 cycle).
- Pop: with rd_en high at edge N, the next entry (or 0/empty) is presented after edge N; back-to-back pops sustain 1 entry/cycle.
- full, almost_full and count update the cycle after the causing edge. The arbiter must sample `full` combinationally before asserting `FIFO_x_en`.
- Throughput: a simultaneous push and pop every cycle is sustained indefinitely at any occupancy.

## Test plan
- Reset, then push 0x00045678, 0x0005678A, 0x000678AB on consecutive cycles with no reads. Required: count=3, instr_out=0x00045678. Three pops then return them in order, and empty=1 with instr_out=0 afterwards.
- Fill DEPTH=8 with 0x10..0x17. Required: full=1 and almost_full=1 from count 6. A 9th push of 0xFF is dropped with overflow=1. Popping all 8 returns 0x10..0x17 with no 0xFF.
- Wrap-around: push 6, pop 6, push 8 (0xA0..0xA7), pop 8. Required: correct order across the pointer wrap, and count returns to 0.
- Full with simultaneous wr_en(0xB0) and rd_en. Required: head popped, count stays 8, 0xB0 lands at tail, overflow stays 0. Empty with simultaneous wr_en(0xC0) and rd_en: count=1, instr_out=0xC0, underflow=1. clr_err then clears underflow.
- Push 5 entries, then assert flush together with wr_en. Required: count=0 and empty=1 next cycle, and the pushed word is discarded.
- Assert resetn=0 mid-stream at count=4, asynchronously between edges. Required: empty=1, count=0 and instr_out=0 immediately, before the next clk edge.
